// File: rtl/sum_disp_pkg.sv
// Shared types and constants for the sum display scanner: FSM encoding, glyphs, word layout.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package sum_disp_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIG0 = 3'd1,
        ST_DIG1 = 3'd2,
        ST_DIG2 = 3'd3,
        ST_DIG3 = 3'd4
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // One adder observation: operands plus the reported {cout,s1,s0}
    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] sum;
    } word_t;

    function automatic logic [6:0] digit_glyph(input logic [2:0] val);
        logic [6:0] g;
        case (val)
            3'd0:    g = GLYPH_0;
            3'd1:    g = GLYPH_1;
            3'd2:    g = GLYPH_2;
            3'd3:    g = GLYPH_3;
            3'd4:    g = GLYPH_4;
            3'd5:    g = GLYPH_5;
            3'd6:    g = GLYPH_6;
            default: g = GLYPH_7;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sum_display_scan_seg7_decode.sv
// Maps {blank, err, val[2:0]} to an active-low 7-segment pattern; blank wins over err.
// Latency: combinational.
// Backpressure: none.
// Ports: blank/err/val in, seg[6:0] out ({g,f,e,d,c,b,a}, active low).
module seg7_decode
    import sum_disp_pkg::*;
(
    input  logic       blank,
    input  logic       err,
    input  logic [2:0] val,
    output logic [6:0] seg
);

    always_comb begin
        seg = GLYPH_BLANK;
        if (blank) begin
            seg = GLYPH_BLANK;
        end else if (err) begin
            seg = GLYPH_E;
        end else begin
            seg = digit_glyph(val);
        end
    end

endmodule

// File: rtl/sum_display_scan.sv
// Shows a 2-bit adder's operands and result on a 4-digit multiplexed 7-segment display.
// Latency: a new word is shown within one frame (4 ticks); seg/an/dp lag the tick edge by one cycle.
// Backpressure: in_ready low while the one-word shadow holds a word not yet copied to the display.
// Ports: CLK100MHZ, CPU_RESETN (async, active low); in_valid/in_ready handshake with in_a, in_b,
//        in_sum; seg[6:0], dp, an[7:0] active-low display drive (an[7:4] always 1).
// Optional build macro SUM_DISP_CHECK_EN: flags words whose sum disagrees with a+b and shows E with dp lit.
module sum_display_scan
    import sum_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int SIM_FAST    = 0
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_a,
    input  logic [1:0] in_b,
    input  logic [2:0] in_sum,
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] an
);

    localparam int PERIOD = (SIM_FAST != 0) ? 4 : REFRESH_DIV;
    localparam int DIV_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD - 1);

    // ---------------- digit slot divider ----------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ---------------- shadow buffer + scan FSM ----------------
    state_t state;
    word_t  shadow;
    word_t  disp;
    logic   shadow_full;
    logic   accept;
    logic   copy;

    assign accept = in_valid && in_ready;
    // Copies happen only when the display is idle or at the frame boundary,
    // so a frame never mixes digits from two different words.
    assign copy   = tick && shadow_full && ((state == ST_IDLE) || (state == ST_DIG3));

`ifdef SUM_DISP_CHECK_EN
    logic disp_err;
    logic shadow_err;
    assign shadow_err = (shadow.sum != ({1'b0, shadow.a} + {1'b0, shadow.b}));
`endif

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state       <= ST_IDLE;
            shadow      <= '0;
            disp        <= '0;
            shadow_full <= 1'b0;
            in_ready    <= 1'b1;
`ifdef SUM_DISP_CHECK_EN
            disp_err    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                shadow <= '{a: in_a, b: in_b, sum: in_sum};
            end

            // accept and copy are mutually exclusive (ready == !full), so
            // ready simply tracks the next-cycle emptiness of the shadow.
            if (accept) begin
                shadow_full <= 1'b1;
            end else if (copy) begin
                shadow_full <= 1'b0;
            end
            in_ready <= !(accept || (shadow_full && !copy));

            if (copy) begin
                disp <= shadow;
`ifdef SUM_DISP_CHECK_EN
                disp_err <= shadow_err;
`endif
            end

            if (tick) begin
                case (state)
                    ST_IDLE: if (shadow_full) state <= ST_DIG0;
                    ST_DIG0: state <= ST_DIG1;
                    ST_DIG1: state <= ST_DIG2;
                    ST_DIG2: state <= ST_DIG3;
                    ST_DIG3: state <= ST_DIG0;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // ---------------- digit content and output registers ----------------
    logic [NUM_DIGITS-1:0] digit_sel;
    logic                  dig_blank;
    logic                  dig_err;
    logic [2:0]            dig_val;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] an_low_q;
    logic [6:0]            seg_q;

    always_comb begin
        digit_sel = '0;
        dig_blank = 1'b1;
        dig_err   = 1'b0;
        dig_val   = 3'd0;
        case (state)
            ST_DIG0: begin
                digit_sel = NUM_DIGITS'(1);
                dig_blank = 1'b0;
                dig_val   = disp.sum;
`ifdef SUM_DISP_CHECK_EN
                dig_err   = disp_err;
`endif
            end
            ST_DIG1: begin
                digit_sel = NUM_DIGITS'(2);
            end
            ST_DIG2: begin
                digit_sel = NUM_DIGITS'(4);
                dig_blank = 1'b0;
                dig_val   = {1'b0, disp.b};
            end
            ST_DIG3: begin
                digit_sel = NUM_DIGITS'(8);
                dig_blank = 1'b0;
                dig_val   = {1'b0, disp.a};
            end
            default: begin
                digit_sel = '0;
            end
        endcase
    end

    seg7_decode u_decode (
        .blank (dig_blank),
        .err   (dig_err),
        .val   (dig_val),
        .seg   (dec_seg)
    );

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            an_low_q <= '1;
            seg_q    <= GLYPH_BLANK;
        end else begin
            an_low_q <= ~digit_sel;
            seg_q    <= dec_seg;
        end
    end

    assign an  = {{(8 - NUM_DIGITS){1'b1}}, an_low_q};
    assign seg = seg_q;

`ifdef SUM_DISP_CHECK_EN
    logic dp_q;
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            dp_q <= 1'b1;
        end else begin
            dp_q <= !((state == ST_DIG0) && disp_err);
        end
    end
    assign dp = dp_q;
`else
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_sum_display_scan.sv
// Directed bench for sum_display_scan with the fast divider (4 cycles per digit slot).
// Latency: n/a.
// Backpressure: exercised by holding in_valid against a full shadow.
module tb_sum_display_scan;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] SE = 7'b0000110, SB = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_a;
    logic [1:0] in_b;
    logic [2:0] in_sum;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;

    int vectors;
    int miscompares;

    sum_display_scan #(.REFRESH_DIV(100000), .SIM_FAST(1)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sum     (in_sum),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Waits (from a negedge) until in_ready is high at a negedge.
    task automatic wait_ready_low_count(output bit ok, output int low_cycles);
        ok = 1'b0;
        low_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            low_cycles++;
            @(negedge clk);
        end
    endtask

    // Counts cycles until an changes; 99 if it never does within 20.
    task automatic step_digit(output int cycles);
        logic [7:0] prev;
        prev = an;
        cycles = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (an !== prev) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic send_word(input logic [1:0] a, input logic [1:0] b, input logic [2:0] s);
        bit ok;
        int lc;
        @(negedge clk);
        in_a = a; in_b = b; in_sum = s; in_valid = 1'b1;
        wait_ready_low_count(ok, lc);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL send_word: in_ready=%b after %0d cycles, required 1", in_ready, lc);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // After a send: wait until the shadow drains, then for the next DIG0 slot.
    task automatic wait_shown(input string name);
        bit ok;
        bit left;
        int lc;
        @(negedge clk);
        wait_ready_low_count(ok, lc);
        left = (an !== 8'hFE);
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (!left) begin
                    if (an !== 8'hFE) left = 1'b1;
                end else if (an === 8'hFE) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_timeout: an=%h in_ready=%b, required DIG0 (an=fe) within budget", name, an, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sum = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({an, seg, dp, in_ready} !== {8'hFF, 7'h7F, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_hold: an=%h seg=%b dp=%b rdy=%b, required ff 1111111 1 1", an, seg, dp, in_ready);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if ({an, seg, in_ready} !== {8'hFF, 7'h7F, 1'b1}) begin
                miscompares++;
                $display("FAIL idle_cycle%0d: an=%h seg=%b rdy=%b, required ff 1111111 1", i, an, seg, in_ready);
            end
        end
    endtask

    task automatic test_frame();
        logic [7:0] an_exp [4]  = '{8'hFD, 8'hFB, 8'hF7, 8'hFE};
        logic [6:0] seg_exp [4] = '{SB, S3, S2, S5};
        int cyc;
        send_word(2'd2, 2'd3, 3'd5);
        wait_shown("frame");
        vectors++;
        if ({an, seg, dp} !== {8'hFE, S5, 1'b1}) begin
            miscompares++;
            $display("FAIL frame_dig0: an=%h seg=%b dp=%b, required fe %b 1", an, seg, dp, S5);
        end
        for (int i = 0; i < 8; i++) begin
            step_digit(cyc);
            vectors++;
            if (cyc != 4 || an !== an_exp[i % 4] || seg !== seg_exp[i % 4]) begin
                miscompares++;
                $display("FAIL frame_step%0d: cycles=%0d an=%h seg=%b, required 4 %h %b",
                         i, cyc, an, seg, an_exp[i % 4], seg_exp[i % 4]);
            end
        end
    endtask

    task automatic test_check();
        logic [6:0] seg_req;
        logic       dp_req;
`ifdef SUM_DISP_CHECK_EN
        seg_req = SE; dp_req = 1'b0;
`else
        seg_req = S3; dp_req = 1'b1;
`endif
        send_word(2'd1, 2'd1, 3'd3);
        wait_shown("check");
        vectors++;
        if ({an, seg, dp} !== {8'hFE, seg_req, dp_req}) begin
            miscompares++;
            $display("FAIL check_dig0: an=%h seg=%b dp=%b, required fe %b %b", an, seg, dp, seg_req, dp_req);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lc;
        @(negedge clk);
        in_a = 2'd1; in_b = 2'd0; in_sum = 3'd1; in_valid = 1'b1;     // word A
        wait_ready_low_count(ok, lc);
        @(negedge clk);
        in_a = 2'd0; in_b = 2'd2; in_sum = 3'd2;                      // word B, held
        wait_ready_low_count(ok, lc);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_accept_b: in_ready=%b, required 1 within budget", in_ready);
        end
        @(negedge clk);
        in_a = 2'd1; in_b = 2'd3; in_sum = 3'd4;                      // word C, held
        wait_ready_low_count(ok, lc);
        vectors++;
        if (!ok || lc != 15) begin
            miscompares++;
            $display("FAIL b2b_ready_low: low for %0d cycles, required 15", lc);
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if ({an, seg, in_ready} !== {8'hFE, S2, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_show_b: an=%h seg=%b rdy=%b, required fe %b 0", an, seg, in_ready, S2);
        end
        wait_shown("b2b_c");
        vectors++;
        if ({an, seg} !== {8'hFE, S4}) begin
            miscompares++;
            $display("FAIL b2b_show_c: an=%h seg=%b, required fe %b", an, seg, S4);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] an_exp [4]  = '{8'hFD, 8'hFB, 8'hF7, 8'hFE};
        logic [6:0] seg_exp [4] = '{SB, S3, S3, S6};
        int cyc;
        int bad;
        send_word(2'd3, 2'd3, 3'd6);
        wait_shown("wrap");
        vectors++;
        if ({an, seg} !== {8'hFE, S6}) begin
            miscompares++;
            $display("FAIL wrap_dig0: an=%h seg=%b, required fe %b", an, seg, S6);
        end
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            step_digit(cyc);
            if (cyc != 4 || an !== an_exp[i % 4] || seg !== seg_exp[i % 4]) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL wrap_100_frames: %0d bad slots, required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lc;
        int bad;
        @(negedge clk);
        in_a = 2'd1; in_b = 2'd1; in_sum = 3'd2; in_valid = 1'b1;
        wait_ready_low_count(ok, lc);
        @(negedge clk);
        in_a = 2'd3; in_b = 2'd0; in_sum = 3'd7;                      // will sit in the shadow
        wait_ready_low_count(ok, lc);
        @(negedge clk);
        in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (an === 8'hFB) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!ok || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_setup: an=%h rdy=%b, required fb 0", an, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({an, seg, dp, in_ready} !== {8'hFF, 7'h7F, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL rstmid_async: an=%h seg=%b dp=%b rdy=%b, required ff 1111111 1 1", an, seg, dp, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an !== 8'hFF || seg !== 7'h7F || in_ready !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rstmid_discard: %0d cycles not blank/ready, required 0", bad);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_frame();
        test_check();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
